// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  typedef enum logic [1:0] {
    FrIdle,
    FrData,
    FrParity,
    FrStop
  } frame_state_t;

  typedef enum logic [1:0] {
    DecBase,
    DecExt,
    DecBrk,
    DecExtBrk
  } decode_state_t;

  typedef struct packed {
    logic       ext;
    logic       press;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous key-event queue; head entry is visible while o_valid is high.
module key_evt_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     Clk,
  input  logic     reset,
  input  logic     i_push,
  input  key_evt_t i_data,
  input  logic     i_pop,
  output logic     o_valid,
  output key_evt_t o_head,
  output logic     o_overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  key_evt_t      r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = i_pop & (r_count != '0);
  // A pop frees the slot this same edge, so a push into a full queue still lands.
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push & w_full & ~w_pop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  assign o_valid    = (r_count != '0);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 keyboard receiver: tick-paced framing, prefix decode, typematic filter, event queue.
module ps2_rx_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 512,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       psClk,
  input  logic       psData,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_press,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [DW-1:0] r_div_cnt;
  logic          w_tick;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
    end
  end

  assign w_tick = (r_div_cnt == DIV_MAX);

  // Sync flops idle high like the bus so reset never fakes a falling edge.
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1 <= psClk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= psData;
      r_dat_s2 <= r_dat_s1;
      if (w_tick) begin
        r_clk_prev <= r_clk_s2;
      end
    end
  end

  assign w_fall = w_tick & r_clk_prev & ~r_clk_s2;

  frame_state_t  r_fstate;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par_bad;
  logic [TW-1:0] r_to_cnt;
  logic          r_frame_err;
  logic          r_byte_done;
  logic [7:0]    r_byte;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_fstate    <= FrIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_bad   <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
      r_byte_done <= 1'b0;
      r_byte      <= '0;
    end else begin
      r_frame_err <= 1'b0;
      r_byte_done <= 1'b0;
      if (w_tick && !w_fall && r_fstate != FrIdle) begin
        if (r_to_cnt == TO_MAX) begin
          r_fstate    <= FrIdle;
          r_frame_err <= 1'b1;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_ONE;
        end
      end
      if (w_fall) begin
        r_to_cnt <= '0;
        unique case (r_fstate)
          FrIdle: begin
            if (!r_dat_s2) begin
              r_fstate  <= FrData;
              r_bit_cnt <= '0;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          FrData: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_fstate <= FrParity;
            end
          end
          FrParity: begin
            r_par_bad <= ~(^{r_shift, r_dat_s2});
            r_fstate  <= FrStop;
          end
          FrStop: begin
            if (r_dat_s2 && !r_par_bad) begin
              r_byte_done <= 1'b1;
              r_byte      <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_fstate <= FrIdle;
          end
          default: r_fstate <= FrIdle;
        endcase
      end
    end
  end

  decode_state_t r_dstate;
  decode_state_t w_dstate_d;
  logic          w_key_valid;
  logic          w_key_press;
  logic          w_key_ext;

  always_comb begin
    w_dstate_d  = r_dstate;
    w_key_valid = 1'b0;
    w_key_press = 1'b0;
    w_key_ext   = 1'b0;
    if (r_byte_done) begin
      w_dstate_d = DecBase;
      if (r_byte == PS2_BRK) begin
        if (r_dstate == DecBase) begin
          w_dstate_d = DecBrk;
        end else if (r_dstate == DecExt) begin
          w_dstate_d = DecExtBrk;
        end
      end else if (r_byte == PS2_EXT && r_dstate == DecBase) begin
        w_dstate_d = DecExt;
      end else if (r_byte != PS2_PAUSE) begin
        w_key_valid = 1'b1;
        w_key_press = (r_dstate == DecBase) || (r_dstate == DecExt);
        w_key_ext   = (r_dstate == DecExt) || (r_dstate == DecExtBrk);
      end
    end
  end

  // Typematic filter: r_last holds the currently pressed {ext, code}, 0 when none.
  logic [8:0] r_last;
  logic [8:0] w_last_d;
  logic [8:0] w_key_id;
  logic       w_push;
  key_evt_t   w_push_evt;
  key_evt_t   w_head;

  assign w_key_id = {w_key_ext, r_byte};

  always_comb begin
    w_last_d = r_last;
    w_push   = 1'b0;
    if (w_key_valid) begin
      if (w_key_press) begin
        if (w_key_id != r_last) begin
          w_push   = 1'b1;
          w_last_d = w_key_id;
        end
      end else begin
        w_push = 1'b1;
        if (w_key_id == r_last) begin
          w_last_d = '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_dstate <= DecBase;
      r_last   <= '0;
    end else begin
      r_dstate <= w_dstate_d;
      r_last   <= w_last_d;
    end
  end

  assign w_push_evt = '{ext: w_key_ext, press: w_key_press, code: r_byte};

  key_evt_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_data    (w_push_evt),
    .i_pop     (evt_ready),
    .o_valid   (evt_valid),
    .o_head    (w_head),
    .o_overflow(overflow)
  );

  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_press = w_head.press;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_sequencer.sv
// Directed bench for ps2_rx_sequencer: bit-banged PS/2 frames against hand-computed events.
module tb_ps2_rx_sequencer;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HALF       = 4 * CLK_DIV;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       psClk = 1'b1;
  logic       psData = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_press;
  logic       frame_err;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;
  int n_ovf    = 0;
  int ferr_base;
  int ovf_base;

  ps2_rx_sequencer #(
    .CLK_DIV   (CLK_DIV),
    .TIMEOUT   (TIMEOUT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .psClk    (psClk),
    .psData   (psData),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_press(evt_press),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 Clk = ~Clk;

  // Counts high cycles; each single-cycle pulse adds exactly one.
  always @(negedge Clk) begin
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk);
    psData = b;
    repeat (HALF) @(negedge Clk);
    psClk = 1'b0;
    repeat (HALF) @(negedge Clk);
    psClk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(bad_par ? ^d : ~^d);
    send_bit(1'b1);
    psData = 1'b1;
    repeat (4 * HALF) @(negedge Clk);
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code, input logic ext,
                            input logic press);
    int waited;
    waited = 0;
    while (!evt_valid && waited < 400) begin
      @(negedge Clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(evt_valid), 32'h1);
    check({tag, "_code"}, 32'(evt_code), 32'(code));
    check({tag, "_ext"}, 32'(evt_ext), 32'(ext));
    check({tag, "_press"}, 32'(evt_press), 32'(press));
    evt_ready = 1'b1;
    @(negedge Clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_code", 32'(evt_code), 32'h0);
    check("rst_ext", 32'(evt_ext), 32'h0);
    check("rst_press", 32'(evt_press), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge Clk);

    // Plain make, then ready while empty must do nothing.
    send_frame(8'h1C, 1'b0);
    expect_evt("t1_make", 8'h1C, 1'b0, 1'b1);
    check("t1_ferr", 32'(n_ferr), 32'h0);
    evt_ready = 1'b1;
    repeat (3) @(negedge Clk);
    evt_ready = 1'b0;
    check("t1_empty", 32'(evt_valid), 32'h0);

    // Break clears last so the same make is accepted again.
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_evt("t2_break", 8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_evt("t2_remake", 8'h1C, 1'b0, 1'b1);

    // Extended make and break.
    send_frame(8'hE0, 1'b0);
    send_frame(8'h74, 1'b0);
    expect_evt("t3_emake", 8'h74, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    expect_evt("t3_ebreak", 8'h74, 1'b1, 1'b0);

    // Typematic repeat: three makes give one event.
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1C, 1'b0);
    expect_evt("t4_make", 8'h1C, 1'b0, 1'b1);
    check("t4_single", 32'(evt_valid), 32'h0);

    // Bad parity, then a stalled frame, then recovery.
    ferr_base = n_ferr;
    send_frame(8'h2B, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (40 * CLK_DIV) @(negedge Clk);
    check("t5_ferr", 32'(n_ferr - ferr_base), 32'h2);
    check("t5_noevt", 32'(evt_valid), 32'h0);
    send_frame(8'h2B, 1'b0);
    expect_evt("t5_good", 8'h2B, 1'b0, 1'b1);
    check("t5_ferr_after", 32'(n_ferr - ferr_base), 32'h2);

    // Overflow: five distinct makes into a four-deep queue.
    ovf_base = n_ovf;
    send_frame(8'h15, 1'b0);
    send_frame(8'h1D, 1'b0);
    send_frame(8'h24, 1'b0);
    send_frame(8'h2D, 1'b0);
    send_frame(8'h2C, 1'b0);
    check("t6_ovf", 32'(n_ovf - ovf_base), 32'h1);
    repeat (20) @(negedge Clk);
    check("t6_hold_code", 32'(evt_code), 32'h15);
    expect_evt("t6_e0", 8'h15, 1'b0, 1'b1);
    expect_evt("t6_e1", 8'h1D, 1'b0, 1'b1);
    expect_evt("t6_e2", 8'h24, 1'b0, 1'b1);
    expect_evt("t6_e3", 8'h2D, 1'b0, 1'b1);
    check("t6_drained", 32'(evt_valid), 32'h0);

    // Reset mid-prefix and mid-frame: next byte decodes from BASE.
    send_frame(8'hE0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    psData = 1'b1;
    repeat (3) @(negedge Clk);
    check("t7_rst_valid", 32'(evt_valid), 32'h0);
    check("t7_rst_ferr", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge Clk);
    ferr_base = n_ferr;
    send_frame(8'h74, 1'b0);
    expect_evt("t7_base", 8'h74, 1'b0, 1'b1);
    check("t7_ferr", 32'(n_ferr - ferr_base), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_sequencer.md
# ps2_rx_sequencer

Controller that sequences reception from a PS/2 keyboard port. It paces sampling of the PS/2 clock and data lines, frames 11-bit packets with start, parity and stop checks, and recovers from stalled frames by timeout. It decodes the E0/F0 prefix byte stream into make/break key events with typematic-repeat suppression. Events are queued in a small FIFO and handed to the game logic over a valid/ready handshake.

## Interface
- CLK_DIV, 512: Clk cycles per sample tick; range ≥ 2.
- TIMEOUT, 64: sample ticks without a PS/2 falling edge before an in-progress frame is aborted.
- FIFO_DEPTH, 4: event queue entries; power of two, ≥ 2.

- Clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- psClk  in  1  raw PS/2 clock pin, asynchronous to Clk.
- psData  in  1  raw PS/2 data pin, asynchronous to Clk.
- evt_valid  out  1  head-of-queue event available.
- evt_ready  in  1  consumer accepts the head event this cycle.
- evt_code  out  8  key code of the head event.
- evt_ext  out  1  head event carried an E0 prefix.
- evt_press  out  1  1 = make (press), 0 = break (release).
- frame_err  out  1  one-cycle pulse: bad start, parity, stop, or timeout.
- overflow  out  1  one-cycle pulse: event dropped because the queue is full.

## Operation
- **Tick generator:** a counter runs 0..CLK_DIV-1; `tick` asserts for one Clk cycle when the count reaches CLK_DIV-1. Only the tick generator is active on every cycle; all other logic advances only on `tick`.
- **Synchronizer:** psClk and psData pass through 2 flops each, clocked every Clk. A third psClk flop is loaded on `tick`. A falling edge is detected when the previous sampled value is 1 and the current is 0. Data is taken from the synchronized psData on that tick.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on a falling edge with data = 0, go to DATA with bit count 0. On data = 1, pulse frame_err and stay in IDLE.
  - DATA: shift data LSB-first into an 8-bit register. After the 8th bit, go to PARITY.
  - PARITY: odd parity required; the XOR of 8 data bits and the parity bit must equal 1. Record a parity failure, then go to STOP.
  - STOP: data must be 1. If stop and parity are good, issue `byte_done` with the byte; otherwise pulse frame_err. Go to IDLE in either case.
  - Timeout: in any non-IDLE state, count ticks since the last falling edge. Reaching TIMEOUT pulses frame_err and forces IDLE. The byte is discarded and the decode FSM is unaffected.
- **Decode FSM** (states BASE, EXT, BRK, EXT_BRK), advancing on `byte_done`:
  - A byte of 0xE0 moves BASE→EXT. A byte of 0xF0 moves BASE→BRK or EXT→EXT_BRK. A byte of 0xE1 is discarded and returns to BASE.
  - Any other byte in BASE or EXT produces a make; in BRK or EXT_BRK it produces a break. The decode FSM then returns to BASE.
  - A byte of 0xF0 received in BRK or EXT_BRK is discarded and returns to BASE.
- **Typematic filter:** `{last_ext, last_code}` is 9 bits, reset 0, with 0 meaning none held.
  - A make equal to `last` is dropped.
  - Any other make is enqueued and updates `last`.
  - A break is always enqueued; if it equals `last`, `last` is cleared to 0.
- **Event FIFO:** entries are `{ext, press, code}`, 10 bits.
  - A push when full drops the event and pulses overflow.
  - A push and a pop in the same cycle while full are both accepted.
  - evt_* outputs show the head entry.

## Timing
- Reset values: evt_valid, frame_err and overflow are 0; evt_code, evt_ext and evt_press are 0. All FSMs are in IDLE/BASE, and all counters and the FIFO are empty.
- Reset asserted mid-frame or mid-prefix aborts immediately. The next frame starts clean in BASE.
- Latency: the event is pushed on the Clk cycle after the tick that samples the stop bit. evt_valid rises on the following cycle (registered FIFO output).
- Handshake: evt_valid and evt_* stay stable until the cycle where evt_ready = 1. The head pops on that edge.
- evt_ready while evt_valid = 0 has no effect.
- frame_err and overflow pulse for exactly one Clk cycle per failure.

## Structure
- Shared package `ps2_pkg` holds:
  - the constants PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_PAUSE = 8'hE1;
  - enums `frame_state_t` and `decode_state_t`;
  - packed struct `key_evt_t {ext, press, code}`.
- Sub-module `key_evt_fifo`, a synchronous FIFO parameterized on FIFO_DEPTH carrying `key_evt_t`. Everything else lives in the top module.

## Test plan
1. Frame 0x1C (start 0, data LSB-first, parity 0, stop 1) → one event with code 0x1C, ext 0, press 1; no frame_err.
2. Bytes F0,1C after the test-1 make → break event 1C, press 0; `last` clears, so a following 1C make is enqueued again.
3. Bytes E0,74 then E0,F0,74 → make {ext 1, code 74}, then break {ext 1, code 74}.
4. Make 0x1C sent three times, no break between → exactly one event queued.
5. Frame with bad parity, then a frame stalled after 4 bits for TIMEOUT ticks → two frame_err pulses and no events. A following good 0x2B frame decodes correctly.
6. FIFO_DEPTH+1 distinct makes with evt_ready = 0 → FIFO_DEPTH events held and one overflow pulse. Asserting evt_ready then drains them in order.
